// File: rtl/full_adder_pipe.sv
// Registered per-lane full adder with a LATENCY-deep valid/data pipeline.
// Optional FULL_ADDER_CARRY_COUNT_EN adds a saturating count of cycles with a valid nonzero carry.
module full_adder_pipe #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] x,
`ifdef FULL_ADDER_CARRY_COUNT_EN
  output logic [WIDTH-1:0] y,
  output logic [15:0]      carry_count
`else
  output logic [WIDTH-1:0] y
`endif
);

  logic [WIDTH-1:0]   sum_d;
  logic [WIDTH-1:0]   carry_d;
  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   x_q [LATENCY];
  logic [WIDTH-1:0]   y_q [LATENCY];

  always_comb begin
    sum_d   = a ^ b ^ c;
    carry_d = (a & b) | (a & c) | (b & c);
  end

  // Data registers load only behind a valid bit, so X on idle inputs never enters the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        x_q[0] <= sum_d;
        y_q[0] <= carry_d;
      end
      for (int unsigned s = 1; s < LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          x_q[s] <= x_q[s-1];
          y_q[s] <= y_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign x         = x_q[LATENCY-1];
  assign y         = y_q[LATENCY-1];

`ifdef FULL_ADDER_CARRY_COUNT_EN
  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (out_valid && (|y) && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign carry_count = count_q;
`endif

endmodule

// File: tb/tb_full_adder_pipe.sv
// Directed bench: one single-lane LATENCY=1 instance and one 4-lane LATENCY=3 instance.
module tb_full_adder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv1, a1, b1, c1, ov1, x1, y1;
  logic       iv3, ov3;
  logic [3:0] a3, b3, c3, x3, y3;
  int         vec_cnt = 0;
  int         miscompares = 0;
`ifdef FULL_ADDER_CARRY_COUNT_EN
  logic [15:0] cnt1;
  logic [15:0] cnt3;
`endif

  always #5 clk = ~clk;

  full_adder_pipe #(.WIDTH(1), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .c(c1),
`ifdef FULL_ADDER_CARRY_COUNT_EN
    .carry_count(cnt1),
`endif
    .out_valid(ov1), .x(x1), .y(y1)
  );

  full_adder_pipe #(.WIDTH(4), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .a(a3), .b(b3), .c(c3),
`ifdef FULL_ADDER_CARRY_COUNT_EN
    .carry_count(cnt3),
`endif
    .out_valid(ov3), .x(x3), .y(y3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    iv3 = 1'b1; a3 = 4'hF; b3 = 4'hF; c3 = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if ({ov1, x1, y1} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_dut1 cyc%0d: got ov/x/y=%b%b%b want 000", i, ov1, x1, y1);
      end
      vec_cnt++;
      if ({ov3, x3, y3} !== 9'b0) begin
        miscompares++;
        $display("FAIL reset_dut3 cyc%0d: got ov=%b x=%b y=%b want 0/0000/0000", i, ov3, x3, y3);
      end
    end
    rst = 1'b0; iv1 = 1'b0; iv3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if ({ov3, x3, y3} !== 9'b0 || {ov1, x1, y1} !== 3'b000) begin
        miscompares++;
        $display("FAIL post_reset cyc%0d: got ov3=%b x3=%b y3=%b ov1/x1/y1=%b%b%b want zeros",
                 i, ov3, x3, y3, ov1, x1, y1);
      end
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_xy [8];
    logic [2:0] abc;
    exp_xy = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int v = 0; v < 8; v++) begin
      abc = 3'(v);
      iv1 = 1'b1; {a1, b1, c1} = abc;
      tick();
      vec_cnt++;
      if (ov1 !== 1'b1 || {x1, y1} !== exp_xy[v]) begin
        miscompares++;
        $display("FAIL truth_abc%b: got ov=%b xy=%b%b want ov=1 xy=%b", abc, ov1, x1, y1,
                 exp_xy[v]);
      end
    end
    iv1 = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    tick();
    vec_cnt++;
    if ({ov1, x1, y1} !== 3'b101) begin
      miscompares++;
      $display("FAIL hold_load: got ov/x/y=%b%b%b want 101", ov1, x1, y1);
    end
    iv1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) a1 = 1'bx;
      tick();
      vec_cnt++;
      if ({ov1, x1, y1} !== 3'b001) begin
        miscompares++;
        $display("FAIL hold_cyc%0d: got ov/x/y=%b%b%b want 001", i, ov1, x1, y1);
      end
    end
    a1 = 1'b0;
  endtask

  task automatic test_latency();
    iv3 = 1'b1; a3 = 4'b1100; b3 = 4'b1010; c3 = 4'b0110;
    tick();
    iv3 = 1'b0; a3 = 4'hF; b3 = 4'hF; c3 = 4'hF;
    for (int e = 2; e <= 4; e++) begin
      tick();
      vec_cnt++;
      if (e == 3) begin
        if (ov3 !== 1'b1 || x3 !== 4'b0000 || y3 !== 4'b1110) begin
          miscompares++;
          $display("FAIL latency_edge3: got ov=%b x=%b y=%b want 1/0000/1110", ov3, x3, y3);
        end
      end else if (ov3 !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_edge%0d: got ov=%b want 0", e, ov3);
      end
    end
    vec_cnt++;
    if (x3 !== 4'b0000 || y3 !== 4'b1110) begin
      miscompares++;
      $display("FAIL latency_hold: got x=%b y=%b want 0000/1110", x3, y3);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic [3:0] vc [4];
    logic [3:0] ex [4];
    logic [3:0] ey [4];
    va = '{4'b1111, 4'b0101, 4'b1111, 4'b1001};
    vb = '{4'b0000, 4'b0011, 4'b1111, 4'b0110};
    vc = '{4'b0000, 4'b0000, 4'b1111, 4'b1111};
    ex = '{4'b1111, 4'b0110, 4'b1111, 4'b0000};
    ey = '{4'b0000, 4'b0001, 4'b1111, 4'b1111};
    for (int t = 0; t < 7; t++) begin
      if (t < 4) begin
        iv3 = 1'b1; a3 = va[t]; b3 = vb[t]; c3 = vc[t];
      end else begin
        iv3 = 1'b0;
      end
      tick();
      if (t >= 2 && t < 6) begin
        vec_cnt++;
        if (ov3 !== 1'b1 || x3 !== ex[t-2] || y3 !== ey[t-2]) begin
          miscompares++;
          $display("FAIL b2b_vec%0d: got ov=%b x=%b y=%b want 1/%b/%b", t - 2, ov3, x3, y3,
                   ex[t-2], ey[t-2]);
        end
      end else if (t == 6) begin
        vec_cnt++;
        if (ov3 !== 1'b0 || x3 !== 4'b0000 || y3 !== 4'b1111) begin
          miscompares++;
          $display("FAIL b2b_tail: got ov=%b x=%b y=%b want 0/0000/1111", ov3, x3, y3);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    iv3 = 1'b1; a3 = 4'b1111; b3 = 4'b1111; c3 = 4'b0000;
    tick();
    a3 = 4'b0001; b3 = 4'b0000; c3 = 4'b0000;
    tick();
    // Third input collides with reset and must be discarded.
    rst = 1'b1; a3 = 4'b1111; c3 = 4'b1111;
    tick();
    rst = 1'b0; iv3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (ov3 !== 1'b0 || x3 !== 4'b0000 || y3 !== 4'b0000) begin
        miscompares++;
        $display("FAIL flush_cyc%0d: got ov=%b x=%b y=%b want 0/0000/0000", i, ov3, x3, y3);
      end
      tick();
    end
    iv3 = 1'b1; a3 = 4'b0011; b3 = 4'b0101; c3 = 4'b0000;
    tick();
    iv3 = 1'b0;
    for (int e = 2; e <= 3; e++) begin
      tick();
      vec_cnt++;
      if (e == 3 && (ov3 !== 1'b1 || x3 !== 4'b0110 || y3 !== 4'b0001)) begin
        miscompares++;
        $display("FAIL after_flush: got ov=%b x=%b y=%b want 1/0110/0001", ov3, x3, y3);
      end else if (e == 2 && ov3 !== 1'b0) begin
        miscompares++;
        $display("FAIL after_flush_early: got ov=%b want 0", ov3);
      end
    end
  endtask

`ifdef FULL_ADDER_CARRY_COUNT_EN
  task automatic test_carry_count();
    logic [2:0] seq [10];
    seq = '{3'b011, 3'b000, 3'b101, 3'b110, 3'b001, 3'b111, 3'b010, 3'b011, 3'b100, 3'b101};
    rst = 1'b1; iv1 = 1'b0;
    tick();
    rst = 1'b0;
    vec_cnt++;
    if (cnt1 !== 16'd0) begin
      miscompares++;
      $display("FAIL count_reset: got %0d want 0", cnt1);
    end
    for (int i = 0; i < 10; i++) begin
      iv1 = 1'b1; {a1, b1, c1} = seq[i];
      tick();
    end
    iv1 = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if (cnt1 !== 16'd6) begin
      miscompares++;
      $display("FAIL count_six: got %0d want 6", cnt1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    iv3 = 1'b0; a3 = '0; b3 = '0; c3 = '0;
    test_reset();
    test_truth_table();
    test_hold();
    test_latency();
    test_back_to_back();
    test_reset_midstream();
`ifdef FULL_ADDER_CARRY_COUNT_EN
    test_carry_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
